mips_pipeline_cpu: RTL and testbench

// - Top-level 5-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-subset CPU with instruction memory,

---
 rtl/mips_pipeline_cpu_pkg.sv | 102 ++++++++++
 rtl/mips_pipeline_cpu_hazard_forward_unit.sv | 58 +++++
 rtl/mips_pipeline_cpu.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mips_pipeline_cpu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pipeline_cpu_pkg.sv
// ----------------------------------------------------------------------------
// mips_pipeline_cpu_pkg
// Shared definitions for the 5-stage MIPS-subset pipeline:
//   - opcode / funct encodings of the supported instructions
//   - ALU operation and forwarding-select enums
//   - control bundle carried from ID into EX
//   - instruction decoder and ALU helper functions
// No ports (package).
// ----------------------------------------------------------------------------
package mips_pipeline_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MUL   = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Control signals consumed in EX and later stages. All-zero is a bubble.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // Unknown opcodes and unknown R-type functs decode to an all-zero bundle,
  // so they flow down the pipe without side effects.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_MUL:  c.alu_op = ALU_MUL;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // 32-bit wrap-around ALU; mul keeps the low word of the product.
  function automatic logic [31:0] alu_calc(input logic signed [31:0] a,
                                           input logic signed [31:0] b,
                                           input alu_op_e op);
    logic [31:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_MUL: r = a * b;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_pipeline_cpu_hazard_forward_unit.sv
// ----------------------------------------------------------------------------
// mips_pipeline_cpu_hazard_forward_unit
// Load-use hazard detection and EX operand forwarding selects.
// Ports:
//   idex_mem_read_i    load in EX
//   idex_rs_i/rt_i     source registers of the instruction in EX
//   ifid_rs_i/rt_i     source registers of the instruction in ID
//   exmem_reg_write_i  EX/MEM writes a register, destination exmem_dst_i
//   memwb_reg_write_i  MEM/WB writes a register, destination memwb_dst_i
//   mux8_o             0 = insert a bubble into ID/EX and hold PC and IF/ID
//   fwd_a_o / fwd_b_o  source select for the rs / rt operand in EX
// ----------------------------------------------------------------------------
module mips_pipeline_cpu_hazard_forward_unit
  import mips_pipeline_cpu_pkg::*;
(
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rs_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_dst_i,
  input  logic       memwb_reg_write_i,
  input  logic [4:0] memwb_dst_i,
  output logic       mux8_o,
  output fwd_sel_e   fwd_a_o,
  output fwd_sel_e   fwd_b_o
);

  // The younger result (EX/MEM) wins over the older one (MEM/WB).
  function automatic fwd_sel_e pick_src(input logic [4:0] src,
                                        input logic       exmem_we,
                                        input logic [4:0] exmem_dst,
                                        input logic       memwb_we,
                                        input logic [4:0] memwb_dst);
    fwd_sel_e s;
    s = FWD_RF;
    if (exmem_we && (exmem_dst != 5'd0) && (exmem_dst == src)) begin
      s = FWD_EXMEM;
    end else if (memwb_we && (memwb_dst != 5'd0) && (memwb_dst == src)) begin
      s = FWD_MEMWB;
    end
    return s;
  endfunction

  always_comb begin
    mux8_o = 1'b1;
    if (idex_mem_read_i && (idex_rt_i != 5'd0) &&
        ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i))) begin
      mux8_o = 1'b0;
    end
    fwd_a_o = pick_src(idex_rs_i, exmem_reg_write_i, exmem_dst_i,
                       memwb_reg_write_i, memwb_dst_i);
    fwd_b_o = pick_src(idex_rt_i, exmem_reg_write_i, exmem_dst_i,
                       memwb_reg_write_i, memwb_dst_i);
  end

endmodule

// File: rtl/mips_pipeline_cpu.sv
// ----------------------------------------------------------------------------
// mips_pipeline_cpu
// 5-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-subset CPU with internal
// instruction memory, data memory and register file. Forwarding into EX,
// one-bubble load-use stall, beq/j resolved in ID with a one-cycle flush.
// Ports:
//   clk_i    single clock, all state updates on posedge
//   rst_i    asynchronous active-low reset (PC and pipeline registers only)
//   start_i  run enable; PC advances only while high, pipeline drains otherwise
// Named scopes PC, Registers, Instruction_Memory, DATAMEMORY, HD, Control and
// EQ give stable hierarchical paths for observing internal state.
// ----------------------------------------------------------------------------
module mips_pipeline_cpu
  import mips_pipeline_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_BYTES);

  // PC and IF/ID
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  // ID/EX
  ctrl_t              idex_ctrl_q, idex_ctrl_d;
  logic [31:0]        idex_rs_data_q, idex_rs_data_d;
  logic [31:0]        idex_rt_data_q, idex_rt_data_d;
  logic signed [31:0] idex_imm_q, idex_imm_d;
  logic [4:0]         idex_rs_q, idex_rs_d;
  logic [4:0]         idex_rt_q, idex_rt_d;
  logic [4:0]         idex_dst_q, idex_dst_d;

  // EX/MEM
  logic        exmem_reg_write_q, exmem_reg_write_d;
  logic        exmem_mem_write_q, exmem_mem_write_d;
  logic        exmem_mem_to_reg_q, exmem_mem_to_reg_d;
  logic [31:0] exmem_alu_q, exmem_alu_d;
  logic [31:0] exmem_store_q, exmem_store_d;
  logic [4:0]  exmem_dst_q, exmem_dst_d;

  // MEM/WB
  logic        memwb_reg_write_q, memwb_reg_write_d;
  logic [31:0] memwb_data_q, memwb_data_d;
  logic [4:0]  memwb_dst_q, memwb_dst_d;

  // ID-stage decode
  logic [5:0]         id_op, id_funct;
  logic [4:0]         id_rs, id_rt, id_rd;
  logic [15:0]        id_imm;
  logic signed [31:0] id_imm_sext;
  logic [31:0]        id_rs_data, id_rt_data;
  ctrl_t              id_ctrl;
  logic               id_reg_dst, id_jump, id_branch, id_eq;
  logic [31:0]        id_br_target, id_j_target;

  // Hazard / forwarding
  logic     hd_mux8, stall;
  fwd_sel_e fwd_a, fwd_b;

  // EX / MEM datapath
  logic [31:0] ex_a, ex_rt_val, ex_b;
  logic [31:0] mem_rdata;

  // ==== IF stage ====
  if (1'b1) begin : PC
    logic [31:0] pc_o;
    assign pc_o   = pc_q;
    assign if_pc4 = pc_o + 32'd4;
  end

  if (1'b1) begin : Instruction_Memory
    logic [31:0] memory [0:IMEM_WORDS-1];
    assign if_instr = memory[pc_q[IA_W+1:2]];
  end

  // Stall holds PC and IF/ID and beats any redirect; the branch is
  // re-evaluated once the bubble has passed. With start_i low, IF/ID is fed
  // NOPs so the instructions already in flight drain out.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    if (!stall) begin
      if (!start_i) begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = '0;
      end else if (id_jump) begin
        pc_d         = id_j_target;
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = '0;
      end else if (id_branch && id_eq) begin
        pc_d         = id_br_target;
        ifid_instr_d = NOP_INSTR;
        ifid_pc4_d   = '0;
      end else begin
        pc_d         = if_pc4;
        ifid_instr_d = if_instr;
        ifid_pc4_d   = if_pc4;
      end
    end
  end

  // ==== ID stage ====
  assign id_op       = ifid_instr_q[31:26];
  assign id_rs       = ifid_instr_q[25:21];
  assign id_rt       = ifid_instr_q[20:16];
  assign id_rd       = ifid_instr_q[15:11];
  assign id_funct    = ifid_instr_q[5:0];
  assign id_imm      = ifid_instr_q[15:0];
  assign id_imm_sext = {{16{id_imm[15]}}, id_imm};

  assign id_br_target = ifid_pc4_q + {id_imm_sext[29:0], 2'b00};
  assign id_j_target  = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};

  // WB write is bypassed into the same-cycle ID read.
  if (1'b1) begin : Registers
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i) begin
      if (memwb_reg_write_q && (memwb_dst_q != 5'd0)) begin
        register[memwb_dst_q] <= memwb_data_q;
      end
    end

    assign id_rs_data = (id_rs == 5'd0) ? 32'd0 :
                        (memwb_reg_write_q && (memwb_dst_q == id_rs)) ? memwb_data_q :
                        register[id_rs];
    assign id_rt_data = (id_rt == 5'd0) ? 32'd0 :
                        (memwb_reg_write_q && (memwb_dst_q == id_rt)) ? memwb_data_q :
                        register[id_rt];
  end

  if (1'b1) begin : Control
    logic jump_o;
    logic branch_o;
    assign jump_o     = (id_op == OP_J);
    assign branch_o   = (id_op == OP_BEQ);
    assign id_jump    = jump_o;
    assign id_branch  = branch_o;
    assign id_ctrl    = decode_ctrl(id_op, id_funct);
    assign id_reg_dst = (id_op == OP_RTYPE);
  end

  // Branch compare sees register-file values only (no forwarding into ID).
  if (1'b1) begin : EQ
    logic data_o;
    assign data_o = (id_rs_data == id_rt_data);
    assign id_eq  = data_o;
  end

  mips_pipeline_cpu_hazard_forward_unit HD (
    .idex_mem_read_i   (idex_ctrl_q.mem_read),
    .idex_rs_i         (idex_rs_q),
    .idex_rt_i         (idex_rt_q),
    .ifid_rs_i         (id_rs),
    .ifid_rt_i         (id_rt),
    .exmem_reg_write_i (exmem_reg_write_q),
    .exmem_dst_i       (exmem_dst_q),
    .memwb_reg_write_i (memwb_reg_write_q),
    .memwb_dst_i       (memwb_dst_q),
    .mux8_o            (hd_mux8),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b)
  );

  assign stall = ~hd_mux8;

  always_comb begin
    idex_ctrl_d    = stall ? ctrl_t'('0) : id_ctrl;
    idex_rs_data_d = id_rs_data;
    idex_rt_data_d = id_rt_data;
    idex_imm_d     = id_imm_sext;
    idex_rs_d      = id_rs;
    idex_rt_d      = id_rt;
    idex_dst_d     = id_reg_dst ? id_rd : id_rt;
  end

  // ==== EX stage ====
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: ex_a = exmem_alu_q;
      FWD_MEMWB: ex_a = memwb_data_q;
      default:   ex_a = idex_rs_data_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: ex_rt_val = exmem_alu_q;
      FWD_MEMWB: ex_rt_val = memwb_data_q;
      default:   ex_rt_val = idex_rt_data_q;
    endcase
    ex_b = idex_ctrl_q.alu_src ? idex_imm_q : ex_rt_val;

    exmem_alu_d        = alu_calc(ex_a, ex_b, idex_ctrl_q.alu_op);
    exmem_store_d      = ex_rt_val;
    exmem_dst_d        = idex_dst_q;
    exmem_reg_write_d  = idex_ctrl_q.reg_write;
    exmem_mem_write_d  = idex_ctrl_q.mem_write;
    exmem_mem_to_reg_d = idex_ctrl_q.mem_to_reg;
  end

  // ==== MEM stage ====
  // Little-endian byte array; the address is taken modulo the memory size
  // and forced to a word boundary.
  if (1'b1) begin : DATAMEMORY
    logic [7:0]      out [0:DMEM_BYTES-1];
    logic [DA_W-1:0] a0, a1, a2, a3;

    assign a0 = {exmem_alu_q[DA_W-1:2], 2'b00};
    assign a1 = {exmem_alu_q[DA_W-1:2], 2'b01};
    assign a2 = {exmem_alu_q[DA_W-1:2], 2'b10};
    assign a3 = {exmem_alu_q[DA_W-1:2], 2'b11};

    always_ff @(posedge clk_i) begin
      if (exmem_mem_write_q) begin
        out[a0] <= exmem_store_q[7:0];
        out[a1] <= exmem_store_q[15:8];
        out[a2] <= exmem_store_q[23:16];
        out[a3] <= exmem_store_q[31:24];
      end
    end

    assign mem_rdata = {out[a3], out[a2], out[a1], out[a0]};
  end

  always_comb begin
    memwb_data_d      = exmem_mem_to_reg_q ? mem_rdata : exmem_alu_q;
    memwb_reg_write_d = exmem_reg_write_q;
    memwb_dst_d       = exmem_dst_q;
  end

  // ==== WB stage / pipeline registers ====
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q               <= '0;
      ifid_instr_q       <= NOP_INSTR;
      ifid_pc4_q         <= '0;
      idex_ctrl_q        <= '0;
      idex_rs_data_q     <= '0;
      idex_rt_data_q     <= '0;
      idex_imm_q         <= '0;
      idex_rs_q          <= '0;
      idex_rt_q          <= '0;
      idex_dst_q         <= '0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_alu_q        <= '0;
      exmem_store_q      <= '0;
      exmem_dst_q        <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_data_q       <= '0;
      memwb_dst_q        <= '0;
    end else begin
      pc_q               <= pc_d;
      ifid_instr_q       <= ifid_instr_d;
      ifid_pc4_q         <= ifid_pc4_d;
      idex_ctrl_q        <= idex_ctrl_d;
      idex_rs_data_q     <= idex_rs_data_d;
      idex_rt_data_q     <= idex_rt_data_d;
      idex_imm_q         <= idex_imm_d;
      idex_rs_q          <= idex_rs_d;
      idex_rt_q          <= idex_rt_d;
      idex_dst_q         <= idex_dst_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_alu_q        <= exmem_alu_d;
      exmem_store_q      <= exmem_store_d;
      exmem_dst_q        <= exmem_dst_d;
      memwb_reg_write_q  <= memwb_reg_write_d;
      memwb_data_q       <= memwb_data_d;
      memwb_dst_q        <= memwb_dst_d;
    end
  end

endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// ----------------------------------------------------------------------------
// tb_mips_pipeline_cpu
// Directed programs with hand-computed register, memory, PC and
// stall/flush expectations for mips_pipeline_cpu.
// ----------------------------------------------------------------------------
module tb_mips_pipeline_cpu;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic start_i = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  int stalls;
  int flushes;
  logic [31:0] pc_first;
  logic [31:0] pc_trace [0:31];

  mips_pipeline_cpu #(
    .IMEM_WORDS (256),
    .DMEM_BYTES (32)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.Instruction_Memory.memory[idx] = w;
  endtask

  // Assert reset and clear program memory.
  task automatic hold_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    @(posedge clk_i);
    #1;
  endtask

  // Release reset with start high and run a fixed number of cycles,
  // tracing PC and counting stall / flush cycles.
  task automatic run(input int ncyc);
    stalls  = 0;
    flushes = 0;
    rst_i   = 1'b1;
    start_i = 1'b1;
    #1;
    pc_first = dut.PC.pc_o;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_i);
      #1;
      if (c < 32) pc_trace[c] = dut.PC.pc_o;
      if (!dut.HD.mux8_o && !dut.Control.jump_o && !dut.Control.branch_o) stalls++;
      if (dut.Control.jump_o || (dut.Control.branch_o && dut.EQ.data_o)) flushes++;
    end
    start_i = 1'b0;
  endtask

  initial begin
    // Reset state and start gating
    hold_reset();
    chk("rst_pc", dut.PC.pc_o, 32'd0);
    chk("rst_mux8", {31'd0, dut.HD.mux8_o}, 32'd1);
    rst_i   = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      chk("idle_pc", dut.PC.pc_o, 32'd0);
    end
    hold_reset();
    run(4);
    chk("start_pc0", pc_first, 32'd0);
    chk("start_pc1", pc_trace[0], 32'd4);
    chk("start_pc2", pc_trace[1], 32'd8);
    chk("start_pc3", pc_trace[2], 32'd12);

    // Taken branch (NOPs let the operands reach the register file first)
    hold_reset();
    put(0, enc_r(6'h20, 5'd10, 5'd0, 5'd0));
    put(1, enc_r(6'h20, 5'd11, 5'd0, 5'd0));
    put(2, enc_i(6'h08, 5'd8, 5'd0, 16'd1));
    put(3, enc_i(6'h08, 5'd9, 5'd0, 16'd1));
    put(4, 32'h0);
    put(5, 32'h0);
    put(6, enc_i(6'h04, 5'd9, 5'd8, 16'd1));
    put(7, enc_i(6'h08, 5'd10, 5'd0, 16'd7));
    put(8, enc_i(6'h08, 5'd11, 5'd0, 16'd2));
    run(20);
    chk("br_r10", dut.Registers.register[10], 32'd0);
    chk("br_r11", dut.Registers.register[11], 32'd2);
    chk("br_flush", flushes, 32'd1);
    chk("br_stall", stalls, 32'd0);

    // Jump to word 4 over two addi $10
    hold_reset();
    put(0, enc_r(6'h20, 5'd10, 5'd0, 5'd0));
    put(1, enc_j(26'd4));
    put(2, enc_i(6'h08, 5'd10, 5'd0, 16'd9));
    put(3, enc_i(6'h08, 5'd10, 5'd0, 16'd9));
    put(4, enc_i(6'h08, 5'd11, 5'd0, 16'd5));
    run(20);
    chk("j_r10", dut.Registers.register[10], 32'd0);
    chk("j_r11", dut.Registers.register[11], 32'd5);
    chk("j_flush", flushes, 32'd1);
    chk("j_pc1", pc_trace[0], 32'd4);
    chk("j_pc2", pc_trace[1], 32'd8);
    chk("j_pc3", pc_trace[2], 32'd16);
    chk("j_pc4", pc_trace[3], 32'd20);

    // EX/MEM and MEM/WB forwarding
    hold_reset();
    put(0, enc_i(6'h08, 5'd8, 5'd0, 16'd5));
    put(1, enc_i(6'h08, 5'd9, 5'd8, 16'd3));
    put(2, enc_r(6'h22, 5'd10, 5'd9, 5'd8));
    run(20);
    chk("fwd_r8", dut.Registers.register[8], 32'd5);
    chk("fwd_r9", dut.Registers.register[9], 32'd8);
    chk("fwd_r10", dut.Registers.register[10], 32'd3);
    chk("fwd_stall", stalls, 32'd0);
    chk("fwd_flush", flushes, 32'd0);

    // Load-use: out[0] is set to 5 by a forwarded store first
    hold_reset();
    put(0, enc_i(6'h08, 5'd1, 5'd0, 16'd5));
    put(1, enc_i(6'h2B, 5'd1, 5'd0, 16'd0));
    put(2, enc_i(6'h23, 5'd8, 5'd0, 16'd0));
    put(3, enc_r(6'h20, 5'd9, 5'd8, 5'd8));
    run(20);
    chk("lu_out0", {24'd0, dut.DATAMEMORY.out[0]}, 32'd5);
    chk("lu_r8", dut.Registers.register[8], 32'd5);
    chk("lu_r9", dut.Registers.register[9], 32'd10);
    chk("lu_stall", stalls, 32'd1);
    chk("lu_flush", flushes, 32'd0);

    // mul then store of the product
    hold_reset();
    put(0, enc_i(6'h08, 5'd8, 5'd0, 16'd6));
    put(1, enc_i(6'h08, 5'd9, 5'd0, 16'd7));
    put(2, enc_r(6'h18, 5'd12, 5'd8, 5'd9));
    put(3, enc_i(6'h2B, 5'd12, 5'd0, 16'd4));
    run(20);
    chk("st_r12", dut.Registers.register[12], 32'd42);
    chk("st_word4", {dut.DATAMEMORY.out[7], dut.DATAMEMORY.out[6],
                     dut.DATAMEMORY.out[5], dut.DATAMEMORY.out[4]}, 32'd42);
    chk("st_out4", {24'd0, dut.DATAMEMORY.out[4]}, 32'd42);
    chk("st_out5", {24'd0, dut.DATAMEMORY.out[5]}, 32'd0);
    chk("st_out6", {24'd0, dut.DATAMEMORY.out[6]}, 32'd0);
    chk("st_out7", {24'd0, dut.DATAMEMORY.out[7]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
